// File: rtl/paraddsub_pkg.sv
// Shared constants for the add/subtract datapath: default width and MODE encodings.
// Latency: n/a. Backpressure: n/a.
// Holds no logic, only parameters.
package paraddsub_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/paraddsub_full_adder.sv
// One-bit full adder, the single stage of the shared ripple-carry chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/paraddsub.sv
// Registered unsigned add/subtract over one shared ripple-carry chain.
// Latency: 1 cycle, one operation accepted every cycle.
// Backpressure: none; no handshake, inputs sampled on every rising edge.
module paraddsub
    import paraddsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Dataout,
    output logic             cout
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Subtract is A + ~B + 1: invert B and inject the +1 as chain carry-in.
    assign sub      = (MODE == MODE_SUB);
    assign b_eff    = B ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dataout <= '0;
        end else begin
            Dataout <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout <= 1'b0;
        end else begin
            cout <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_paraddsub.sv
// Bench for paraddsub at WIDTH=4: directed vectors, MODE toggling, mid-stream reset, random vectors.
// Expected {cout,Dataout} values are queued at drive time and popped one cycle later.
module tb_paraddsub;
    import paraddsub_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] dataout;
    logic         cout;

    int tests_run;
    int tests_failed;

    logic [W:0] sb[$];

    paraddsub #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MODE    (mode),
        .A       (a),
        .B       (b),
        .Dataout (dataout),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        if (m == MODE_ADD) r = {1'b0, x} + {1'b0, y};
        else               r = {1'b0, x} + {1'b0, ~y} + 1'b1;
        return r;
    endfunction

    // Drive a new operation between edges and queue its expected result.
    task automatic drive_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        mode = m;
        a    = x;
        b    = y;
        sb.push_back(model(m, x, y));
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({cout, dataout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_async got=%b required=%b", {cout, dataout}, 5'b0);
        end
        mode = MODE_ADD; a = 4'hF; b = 4'hF;
        @(posedge clk); #1;
        tests_run++;
        if ({cout, dataout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_hold got=%b required=%b", {cout, dataout}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W:0] req [4];
        logic [W:0] exp;
        req[0] = 5'b0_1000;
        req[1] = 5'b1_0000;
        req[2] = 5'b1_0101;
        req[3] = 5'b0_1100;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive_op(MODE_ADD, 4'b0101, 4'b0011);
                1: drive_op(MODE_ADD, 4'b1111, 4'b0001);
                2: drive_op(MODE_SUB, 4'b1001, 4'b0100);
                default: drive_op(MODE_SUB, 4'b0011, 4'b0111);
            endcase
            @(posedge clk); #1;
            exp = sb.pop_front();
            tests_run++;
            if ({cout, dataout} !== exp || exp !== req[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d got=%b model=%b required=%b", i, {cout, dataout}, exp, req[i]);
            end
        end
    endtask

    task automatic test_mode_toggle;
        logic [W:0] exp;
        drive_op(MODE_SUB, 4'b0110, 4'b0110);
        @(posedge clk); #1;
        exp = sb.pop_front();
        tests_run++;
        if ({cout, dataout} !== 5'b1_0000 || exp !== 5'b1_0000) begin
            tests_failed++;
            $display("FAIL equal_sub got=%b required=%b", {cout, dataout}, 5'b1_0000);
        end
        drive_op(MODE_ADD, 4'b0110, 4'b0110);
        @(posedge clk); #1;
        exp = sb.pop_front();
        tests_run++;
        if ({cout, dataout} !== 5'b0_1100 || exp !== 5'b0_1100) begin
            tests_failed++;
            $display("FAIL toggle_add got=%b required=%b", {cout, dataout}, 5'b0_1100);
        end
    endtask

    task automatic test_reset_midstream;
        logic [W:0] exp;
        drive_op(MODE_ADD, 4'b0111, 4'b1010);
        @(posedge clk); #1;
        exp = sb.pop_front();
        tests_run++;
        if ({cout, dataout} !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset got=%b required=%b", {cout, dataout}, exp);
        end
        drive_op(MODE_SUB, 4'b1100, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cout, dataout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_immediate got=%b required=%b", {cout, dataout}, 5'b0);
        end
        sb.delete();
        @(posedge clk); #1;
        tests_run++;
        if ({cout, dataout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_discard got=%b required=%b", {cout, dataout}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model(mode, a, b));
        @(posedge clk); #1;
        exp = sb.pop_front();
        tests_run++;
        if ({cout, dataout} !== exp || exp !== 5'b1_1011) begin
            tests_failed++;
            $display("FAIL post_release got=%b required=%b", {cout, dataout}, 5'b1_1011);
        end
    endtask

    task automatic test_random;
        logic [W:0] exp;
        for (int i = 0; i < 10; i++) begin
            drive_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            @(posedge clk); #1;
            exp = sb.pop_front();
            tests_run++;
            if ({cout, dataout} !== exp) begin
                tests_failed++;
                $display("FAIL random_%0d mode=%b a=%b b=%b got=%b required=%b",
                         i, mode, a, b, {cout, dataout}, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive_op(1'(i % 2), W'(i), W'(15 - i));
            @(posedge clk); #1;
            exp = sb.pop_front();
            tests_run++;
            if ({cout, dataout} !== exp) begin
                tests_failed++;
                $display("FAIL b2b_%0d got=%b required=%b", i, {cout, dataout}, exp);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        mode  = MODE_ADD;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_mode_toggle();
        test_reset_midstream();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/paraddsub.md
PARADDSUB -- requirements
Module: paraddsub

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result bit width (legal values 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port MODE  input  1  operation select: 0 = add, 1 = subtract.
REQ-005 SHALL have port A  input  WIDTH  first operand, unsigned.
REQ-006 SHALL have port B  input  WIDTH  second operand, unsigned.
REQ-007 SHALL have port Dataout  output  WIDTH  registered result.
REQ-008 SHALL have port cout  output  1  registered carry-out of the adder chain.
REQ-009 SHALL use the ports in this instantiation order: MODE, A, B, Dataout, cout, with clk and rst_n placed first.

Function
REQ-010 SHALL compute the result with one shared ripple-carry adder chain for both operations.
REQ-011 SHALL feed each adder stage with B[i] XOR MODE and use MODE as the chain carry-in.
REQ-012 SHALL, with MODE=0, produce {cout,Dataout} = A + B, width WIDTH+1, no saturation.
REQ-013 SHALL, with MODE=1, produce {cout,Dataout} = A + ~B + 1, i.e. Dataout = (A - B) mod 2^WIDTH.
REQ-014 SHALL, with MODE=1, drive cout = 1 when A >= B (no borrow) and cout = 0 when A < B (borrow).
REQ-015 SHALL register Dataout and cout on every rising clk edge.
REQ-016 SHALL show the result of inputs sampled at edge N on the outputs immediately after edge N; latency is 1 cycle and a new operation is accepted every cycle.
REQ-017 SHALL have no handshake and no enable; inputs are sampled on every edge.
REQ-018 SHALL keep the add/subtract decision combinational from MODE, so MODE may change on any cycle without a pipeline bubble.
REQ-019 SHALL wrap on overflow (add) and on underflow (subtract) modulo 2^WIDTH, with the lost carry or borrow reported only via cout.
REQ-020 SHALL, with A=B and MODE=1, give Dataout=0 and cout=1.
REQ-021 SHALL not contain X-propagating constructs; every output bit SHALL be defined after reset.

Reset
REQ-022 SHALL, while rst_n=0, force Dataout=0 and cout=0 immediately, independent of clk.
REQ-023 SHALL, after rst_n deasserts, produce its first valid result on the first rising edge.
REQ-024 SHALL, when reset is asserted mid-stream, discard the in-flight result; no stale value SHALL reappear after release.

Structure
REQ-025 SHALL take the WIDTH default constant and the MODE encodings MODE_ADD=1'b0 and MODE_SUB=1'b1 from the shared package paraddsub_pkg.
REQ-026 SHALL build the adder chain from WIDTH instances of the single sub-module full_adder (ports a, b, cin, sum, cout), generated in a loop.
REQ-027 SHALL contain only two flops groups in the top level: the Dataout register and the cout register.

Verification (WIDTH=4, check one cycle after applying inputs)
REQ-028 SHALL cover: A=0101, B=0011, MODE=0 -> Dataout=1000, cout=0.
REQ-029 SHALL cover: A=1111, B=0001, MODE=0 -> Dataout=0000, cout=1 (overflow wrap).
REQ-030 SHALL cover: A=1001, B=0100, MODE=1 -> Dataout=0101, cout=1.
REQ-031 SHALL cover: A=0011, B=0111, MODE=1 -> Dataout=1100, cout=0 (borrow).
REQ-032 SHALL cover: A=B=0110, MODE=1 -> Dataout=0000, cout=1; then MODE toggled to 0 on the next cycle -> Dataout=1100, cout=0.
REQ-033 SHALL cover: rst_n pulled low between edges while outputs are non-zero -> Dataout=0000 and cout=0 at once; after release, the first edge shows the current inputs' result.
REQ-034 SHALL cover 10 random vectors (A, B, MODE) checked against a reference model of REQ-012 and REQ-013.
